// File: rtl/l1_cache_pkg.sv
// l1_cache_pkg
// Shared L1 cache constants and types: tag array geometry and the
// tag SRAM controller state encoding.
package l1_cache_pkg;

    localparam int L1_TAG_DATA_WIDTH = 19;
    localparam int L1_TAG_ADDR_WIDTH = 8;
    localparam int L1_TAG_DEPTH      = 256;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } tag_state_e;

endpackage : l1_cache_pkg

// File: rtl/l1_tag_sram_ctrl.sv
// l1_tag_sram_ctrl
// Front end for a dual-port (1W/1R) tag SRAM macro.
// - Clears the whole array after reset.
// - Then accepts write and read requests.
// - Read data is returned with a latency of one cycle.
//
// Optional feature: define L1_TAG_SRAM_BYPASS_EN to forward write data to a
// read of the same address in the same cycle. Without the macro, the read is
// stalled for that cycle instead.
import l1_cache_pkg::*;

module l1_tag_sram_ctrl #(
    parameter int DATA_WIDTH = L1_TAG_DATA_WIDTH,
    parameter int ADDR_WIDTH = L1_TAG_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  init_done,
    output logic                  sram_csb0,
    output logic [ADDR_WIDTH-1:0] sram_addr0,
    output logic [DATA_WIDTH-1:0] sram_din0,
    output logic                  sram_csb1,
    output logic [ADDR_WIDTH-1:0] sram_addr1,
    input  logic [DATA_WIDTH-1:0] sram_dout1
);

    tag_state_e            state;
    tag_state_e            state_nxt;
    logic [ADDR_WIDTH-1:0] init_cnt;
    logic                  init_last;
    logic                  collision;
    logic                  rd_fire;
    logic                  rd_pend;

    assign init_last = (init_cnt == '1);
    assign collision = wr_valid && rd_valid && (wr_addr == rd_addr);
    assign init_done = (state == S_RUN);

`ifdef L1_TAG_SRAM_BYPASS_EN
    logic                  rd_bypass;
    logic                  rd_pend_bypass;
    logic [DATA_WIDTH-1:0] bypass_data;

    // A read that collides with a same-cycle write is served from wr_data, not from the array.
    assign rd_bypass = rd_fire && collision;
`endif

    // State register and clear-sweep counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_INIT;
            init_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_INIT) begin
                init_cnt <= init_cnt + ADDR_WIDTH'(1);
            end
        end
    end

    // Next state, handshakes and SRAM port drive. Both chip selects are held off while reset is low.
    always_comb begin
        state_nxt  = state;
        wr_ready   = 1'b0;
        rd_ready   = 1'b0;
        rd_fire    = 1'b0;
        sram_csb0  = 1'b1;
        sram_addr0 = wr_addr;
        sram_din0  = wr_data;
        sram_csb1  = 1'b1;
        sram_addr1 = rd_addr;
        if (rst_n) begin
            case (state)
                S_INIT: begin
                    sram_csb0  = 1'b0;
                    sram_addr0 = init_cnt;
                    sram_din0  = '0;
                    if (init_last) begin
                        state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    wr_ready = 1'b1;
`ifdef L1_TAG_SRAM_BYPASS_EN
                    rd_ready = 1'b1;
`else
                    rd_ready = !collision;
`endif
                    rd_fire = rd_valid && rd_ready;
                    if (wr_valid) begin
                        sram_csb0 = 1'b0;
                    end
`ifdef L1_TAG_SRAM_BYPASS_EN
                    if (rd_fire && !collision) begin
                        sram_csb1 = 1'b0;
                    end
`else
                    if (rd_fire) begin
                        sram_csb1 = 1'b0;
                    end
`endif
                end
                default: begin
                    state_nxt = S_INIT;
                end
            endcase
        end
    end

    // Read response pipeline.
    // - The SRAM output settles after the falling edge that follows capture.
    // - It is therefore registered one edge after the read is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_pend   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
`ifdef L1_TAG_SRAM_BYPASS_EN
            rd_pend_bypass <= 1'b0;
            bypass_data    <= '0;
`endif
        end else begin
            rd_pend   <= rd_fire;
            rsp_valid <= rd_pend;
`ifdef L1_TAG_SRAM_BYPASS_EN
            rd_pend_bypass <= rd_bypass;
            if (rd_bypass) begin
                bypass_data <= wr_data;
            end
            if (rd_pend) begin
                rsp_data <= rd_pend_bypass ? bypass_data : sram_dout1;
            end
`else
            if (rd_pend) begin
                rsp_data <= sram_dout1;
            end
`endif
        end
    end

endmodule : l1_tag_sram_ctrl

// File: tb/tb_l1_tag_sram_ctrl.sv
// tb_l1_tag_sram_ctrl
// Bench for l1_tag_sram_ctrl.
// - Contains a behavioural 1W/1R SRAM macro.
// - Contains a reference model: expected array contents plus a queue of responses due by cycle number.
// - Runs directed scenarios followed by randomized traffic.
// Honours L1_TAG_SRAM_BYPASS_EN in the same way as the design.
module tb_l1_tag_sram_ctrl;

    localparam int DW = 19;
    localparam int AW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          wr_valid;
    logic          wr_ready;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          rd_valid;
    logic          rd_ready;
    logic [AW-1:0] rd_addr;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          init_done;
    logic          sram_csb0;
    logic [AW-1:0] sram_addr0;
    logic [DW-1:0] sram_din0;
    logic          sram_csb1;
    logic [AW-1:0] sram_addr1;
    logic [DW-1:0] sram_dout1;

    l1_tag_sram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_valid   (rd_valid),
        .rd_ready   (rd_ready),
        .rd_addr    (rd_addr),
        .rsp_valid  (rsp_valid),
        .rsp_data   (rsp_data),
        .init_done  (init_done),
        .sram_csb0  (sram_csb0),
        .sram_addr0 (sram_addr0),
        .sram_din0  (sram_din0),
        .sram_csb1  (sram_csb1),
        .sram_addr1 (sram_addr1),
        .sram_dout1 (sram_dout1)
    );

    always #5 clk = ~clk;

    // Behavioural SRAM macro.
    // - Writes happen on the rising edge.
    // - Read data appears after the following falling edge; otherwise the output is garbage.
    logic [DW-1:0] sram_mem [DEPTH];
    logic [AW-1:0] sram_rd_lat;
    logic          sram_rd_cap = 1'b0;

    always @(posedge clk) begin
        if (!sram_csb0) sram_mem[sram_addr0] <= sram_din0;
        sram_rd_cap <= !sram_csb1;
        if (!sram_csb1) sram_rd_lat <= sram_addr1;
    end

    always @(negedge clk) begin
        if (sram_rd_cap) sram_dout1 = sram_mem[sram_rd_lat];
        else             sram_dout1 = DW'($urandom);
    end

    // Reference model state.
    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          exp_q[$];
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] last_rsp;
    bit            in_run;
    bit            primed;
    int            sweep_idx;
    int            cyc;
    int            tests;
    int            fails;
`ifdef L1_TAG_SRAM_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit rn, input bit wv, input logic [AW-1:0] wa,
                                 input logic [DW-1:0] wd, input bit rv, input logic [AW-1:0] ra);
        rst_n    = rn;
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        rd_valid = rv;
        rd_addr  = ra;
    endtask

    // One clock cycle:
    // - Drive the inputs.
    // - Check every output against the model at the falling edge.
    // - Advance the model.
    // - Wait for the rising edge.
    task automatic runCycle(input bit rn, input bit wv, input logic [AW-1:0] wa,
                            input logic [DW-1:0] wd, input bit rv, input logic [AW-1:0] ra);
        bit            coll;
        bit            exp_rr;
        bit            rd_take;
        bit            exp_v;
        logic [DW-1:0] rdata;
        applyStimulus(rn, wv, wa, wd, rv, ra);
        @(negedge clk);
        cyc++;
        if (primed) begin
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
            checkOutput("rsp_valid", 32'(rsp_valid), 32'(exp_v));
            if (exp_v) begin
                checkOutput("rsp_data", 32'(rsp_data), 32'(exp_q[0].data));
                last_rsp = exp_q[0].data;
                void'(exp_q.pop_front());
            end else begin
                checkOutput("rsp_hold", 32'(rsp_data), 32'(last_rsp));
            end
        end
        if (!rn) begin
            checkOutput("rst_csb0", 32'(sram_csb0), 32'd1);
            checkOutput("rst_csb1", 32'(sram_csb1), 32'd1);
            exp_q.delete();
            last_rsp  = '0;
            in_run    = 1'b0;
            sweep_idx = 0;
            primed    = 1'b1;
        end else if (!in_run) begin
            checkOutput("init_csb0", 32'(sram_csb0), 32'd0);
            checkOutput("init_addr0", 32'(sram_addr0), 32'(sweep_idx));
            checkOutput("init_din0", 32'(sram_din0), 32'd0);
            checkOutput("init_csb1", 32'(sram_csb1), 32'd1);
            checkOutput("init_wr_ready", 32'(wr_ready), 32'd0);
            checkOutput("init_rd_ready", 32'(rd_ready), 32'd0);
            checkOutput("init_done_low", 32'(init_done), 32'd0);
            ref_mem[sweep_idx] = '0;
            if (sweep_idx == DEPTH - 1) in_run = 1'b1;
            else sweep_idx++;
        end else begin
            coll    = wv && rv && (wa == ra);
            exp_rr  = BYPASS ? 1'b1 : !coll;
            rd_take = rv && exp_rr;
            checkOutput("init_done_high", 32'(init_done), 32'd1);
            checkOutput("wr_ready", 32'(wr_ready), 32'd1);
            checkOutput("rd_ready", 32'(rd_ready), 32'(exp_rr));
            checkOutput("csb0", 32'(sram_csb0), 32'(!wv));
            if (wv) begin
                checkOutput("addr0", 32'(sram_addr0), 32'(wa));
                checkOutput("din0", 32'(sram_din0), 32'(wd));
            end
            checkOutput("csb1", 32'(sram_csb1), 32'(!(rd_take && !coll)));
            if (rd_take && !coll) checkOutput("addr1", 32'(sram_addr1), 32'(ra));
            checkOutput("port_clash", 32'(!sram_csb0 && !sram_csb1 && sram_addr0 == sram_addr1), 32'd0);
            if (rd_take) begin
                rdata = coll ? wd : ref_mem[ra];
                exp_q.push_back('{due: cyc + 2, data: rdata});
            end
            if (wv) ref_mem[wa] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) runCycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
    endtask

    task automatic initSweep(input int n);
        for (int i = 0; i < n; i++)
            runCycle(1'b1, 1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom), AW'($urandom));
    endtask

    task automatic resetCycles(input int n);
        for (int i = 0; i < n; i++)
            runCycle(1'b0, 1'($urandom), AW'($urandom), DW'($urandom), 1'($urandom), AW'($urandom));
    endtask

    // Directed scenarios first, then randomized traffic biased toward a few hot addresses so collisions occur.
    initial begin
        tests = 0; fails = 0; cyc = 0;
        primed = 1'b0; in_run = 1'b0; sweep_idx = 0; last_rsp = '0;
        resetCycles(3);
        initSweep(DEPTH);
        idle(1);
        runCycle(1'b1, 1'b0, '0, '0, 1'b1, 8'h80);
        idle(2);
        runCycle(1'b1, 1'b1, 8'h12, 19'h7FFFF, 1'b0, '0);
        runCycle(1'b1, 1'b0, '0, '0, 1'b1, 8'h12);
        idle(3);
        for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b1, AW'(i), DW'(i + 1), 1'b0, '0);
        for (int i = 0; i < 4; i++) runCycle(1'b1, 1'b0, '0, '0, 1'b1, AW'(i));
        idle(3);
        runCycle(1'b1, 1'b1, 8'h40, 19'h00ABC, 1'b1, 8'h40);
        runCycle(1'b1, 1'b0, '0, '0, 1'b1, 8'h40);
        idle(3);
        runCycle(1'b1, 1'b0, '0, '0, 1'b1, 8'h12);
        resetCycles(2);
        initSweep(101);
        resetCycles(1);
        initSweep(DEPTH);
        for (int i = 0; i < 3000; i++) begin
            logic [AW-1:0] wa;
            logic [AW-1:0] ra;
            wa = ($urandom_range(0, 3) != 0) ? AW'(8'h40 + $urandom_range(0, 3)) : AW'($urandom);
            ra = ($urandom_range(0, 3) != 0) ? AW'(8'h40 + $urandom_range(0, 3)) : AW'($urandom);
            runCycle(1'b1, 1'($urandom), wa, DW'($urandom), 1'($urandom), ra);
        end
        idle(3);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_l1_tag_sram_ctrl

// File: doc/l1_tag_sram_ctrl.md
L1_TAG_SRAM_CTRL -- requirements
Module: l1_tag_sram_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 19, SRAM word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, SRAM address width (depth 1<<ADDR_WIDTH).
REQ-003 The block SHALL have ports:
- clk  in  1  single clock, shared with the SRAM clk0/clk1.
- rst_n  in  1  reset, synchronous, active-low.
- wr_valid  in  1  write request.
- wr_ready  out  1  write accepted on clk rise when wr_valid&&wr_ready.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  DATA_WIDTH  write data.
- rd_valid  in  1  read request.
- rd_ready  out  1  read accepted on clk rise when rd_valid&&rd_ready.
- rd_addr  in  ADDR_WIDTH  read address.
- rsp_valid  out  1  one-cycle read response strobe; no backpressure.
- rsp_data  out  DATA_WIDTH  read response data.
- init_done  out  1  array clear complete.
- sram_csb0  out  1  SRAM write-port chip select, active-low.
- sram_addr0  out  ADDR_WIDTH  SRAM write address.
- sram_din0  out  DATA_WIDTH  SRAM write data.
- sram_csb1  out  1  SRAM read-port chip select, active-low.
- sram_addr1  out  ADDR_WIDTH  SRAM read address.
- sram_dout1  in  DATA_WIDTH  SRAM read data, valid after the falling edge following capture.

Function
REQ-004 FSM states SHALL be S_INIT and S_RUN; S_INIT SHALL be entered on reset.
REQ-005 In S_INIT, the block SHALL drive sram_csb0=0, sram_addr0=init_cnt, sram_din0=0 each cycle, with init_cnt counting 0..(1<<ADDR_WIDTH)-1.
REQ-006 In S_INIT, wr_ready, rd_ready and init_done SHALL be 0 and sram_csb1 SHALL be 1.
REQ-007 After the clock edge that captures address (1<<ADDR_WIDTH)-1, the FSM SHALL move to S_RUN and init_done SHALL be 1 until the next reset.
REQ-008 In S_RUN, wr_ready SHALL be 1.
REQ-009 In S_RUN, an accepted write SHALL drive sram_csb0=0, sram_addr0=wr_addr and sram_din0=wr_data combinationally in the accepting cycle; otherwise sram_csb0 SHALL be 1.
REQ-010 In S_RUN, an accepted read SHALL drive sram_csb1=0 and sram_addr1=rd_addr combinationally in the accepting cycle; otherwise sram_csb1 SHALL be 1.
REQ-011 For a read accepted at edge E, the block SHALL register sram_dout1 at edge E+1 and hold rsp_valid=1 for exactly the cycle E+1..E+2 (latency 1).
REQ-012 Back-to-back reads SHALL be accepted every cycle, giving one rsp_valid per cycle in order.
REQ-013 A write accepted at edge E followed by a read of the same address at E+1 SHALL return the written data.
REQ-014 The same-cycle write/read collision (same address, both valid) SHALL be handled per REQ-018/REQ-019 and SHALL never present csb0=0 and csb1=0 to the SRAM with addr0==addr1.
REQ-015 rsp_data SHALL hold its last value when rsp_valid=0.

Reset
REQ-016 On clk rise with rst_n=0, the block SHALL set:
- FSM=S_INIT, init_cnt=0.
- rsp_valid=0, rsp_data=0, init_done=0.
- Any in-flight response dropped.
- sram_csb0 and sram_csb1 deasserted during the reset cycle.
REQ-017 A reset asserted during S_INIT or S_RUN SHALL restart the full clear sweep from address 0.

Configuration
REQ-018 With L1_TAG_SRAM_BYPASS_EN defined, a same-cycle collision SHALL accept both requests, issue only the write to the SRAM (sram_csb1=1), and return wr_data as rsp_data at latency 1.
REQ-019 Without L1_TAG_SRAM_BYPASS_EN, rd_ready SHALL be 0 during a same-cycle collision; the write proceeds and the read is accepted in a later cycle.

Structure
REQ-020 The shared package l1_cache_pkg SHALL hold L1_TAG_DATA_WIDTH=19, L1_TAG_ADDR_WIDTH=8, L1_TAG_DEPTH=256 and the FSM state enum.
REQ-021 The block SHALL have no sub-module; the SRAM macro SHALL be instantiated by the parent and connected through the sram_* ports.

Verification
REQ-022 Release rst_n, then count cycles -> 256 consecutive writes of 0 to addr 0..255, init_done=1 on cycle 256, and a read of 0x80 returns 0.
REQ-023 Write 0x7FFFF to addr 0x12, read 0x12 on the next cycle -> rsp_valid one cycle later with rsp_data=0x7FFFF.
REQ-024 Four reads on consecutive cycles to 0x00..0x03 after writing 1..4 -> four consecutive rsp_valid pulses with data 1,2,3,4.
REQ-025 Same-cycle write 0x00ABC and read, both at 0x40:
- With L1_TAG_SRAM_BYPASS_EN: rsp_data=0x00ABC at latency 1, sram_csb1=1 in the collision cycle.
- Without it: rd_ready=0 in the collision cycle, then rsp_data=0x00ABC.
REQ-026 Assert rst_n=0 mid-read and at init_cnt=100 -> rsp_valid never pulses for the dropped read, and the sweep restarts at address 0.
